// File: rtl/fb_scan_arbiter_if.sv
// fb_scan_arbiter_if: bundle of scan-out, writer and RAM signals around the framebuffer arbiter.
//   ce, pixel_en : pixel-clock enable and visible-area flag from the VGA timing module
//   pixel        : registered pixel for the current visible position
//   wr_valid, wr_addr, wr_data, wr_ready : writer valid/ready handshake
//   ram_addr, ram_we, ram_wdata, ram_rdata : single-port synchronous RAM (read data one cycle late)
//   underrun     : sticky flag, a pixel was consumed before its fetch completed
//   slave modport is the arbiter's view, master modport is the surrounding system's view.
interface fb_scan_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              ce;
    logic              pixel_en;
    logic [DATA_W-1:0] pixel;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              underrun;
    modport slave (
        input  ce, pixel_en, wr_valid, wr_addr, wr_data, ram_rdata,
        output pixel, wr_ready, ram_addr, ram_we, ram_wdata, underrun
    );
    modport master (
        output ce, pixel_en, wr_valid, wr_addr, wr_data, ram_rdata,
        input  pixel, wr_ready, ram_addr, ram_we, ram_wdata, underrun
    );
endinterface

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares one single-port framebuffer RAM between scan-out (absolute priority,
// one-pixel prefetch) and a pixel writer that gets every remaining RAM cycle.
//   i_clk : system clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : fb_scan_arbiter_if.slave (scan-out, writer handshake, RAM port, underrun flag)
module fb_scan_arbiter #(
    parameter int H_PIXELS = 8,
    parameter int V_PIXELS = 8,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    fb_scan_arbiter_if.slave bus
);
    localparam int N = H_PIXELS * V_PIXELS;
    typedef enum logic {IDLE, FETCH} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pending;
    logic              r_underrun;
    logic [DATA_W-1:0] r_pixel;
    logic              w_consume;
    logic              w_fetch;
    logic              w_xfer;
    assign w_consume     = bus.ce & bus.pixel_en;
    assign w_fetch       = (r_state == IDLE) & r_pending;
    assign bus.wr_ready  = !i_rst & !w_fetch;
    assign w_xfer        = bus.wr_valid & bus.wr_ready;
    assign bus.ram_we    = w_xfer;
    assign bus.ram_wdata = bus.wr_data;
    // the address bus parks on its last value when the RAM is unused
    assign bus.ram_addr  = w_fetch ? r_rd_ptr : w_xfer ? bus.wr_addr : r_addr;
    assign bus.pixel     = r_pixel;
    assign bus.underrun  = r_underrun;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rd_ptr   <= '0;
            r_pending  <= 1'b1;
            r_pixel    <= '0;
            r_underrun <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_addr    <= bus.ram_addr;
            r_state   <= w_fetch ? FETCH : IDLE;
            // a consume in the issuing cycle re-arms the prefetch for the newer pointer
            r_pending <= w_consume | (r_pending & !w_fetch);
            if (r_state == FETCH)
                r_pixel <= bus.ram_rdata;
            if (w_consume) begin
                r_rd_ptr <= (r_rd_ptr == ADDR_W'(N - 1)) ? '0 : r_rd_ptr + ADDR_W'(1);
                if (r_pending | (r_state == FETCH))
                    r_underrun <= 1'b1;
            end
        end
    end
endmodule
